// File: rtl/cp0_tlb_regs_pkg.sv
// Shared definitions for the CP0 TLB-management register file:
// register numbers, field positions and per-register writable masks.
package cp0_tlb_regs_pkg;

  localparam int TLB_LINE_NUM      = 32;
  localparam int LOG2_TLB_LINE_NUM = $clog2(TLB_LINE_NUM);

  // CP0 register numbers (select 0)
  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_PAGEMASK = 5'd5;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  // Field ranges
  localparam int VPN2_MSB      = 31;
  localparam int VPN2_LSB      = 13;
  localparam int ASID_MSB      = 7;
  localparam int ASID_LSB      = 0;
  localparam int PFN_MSB       = 25;
  localparam int PFN_LSB       = 6;
  localparam int C_MSB         = 5;
  localparam int C_LSB         = 3;
  localparam int D_BIT         = 2;
  localparam int V_BIT         = 1;
  localparam int G_BIT         = 0;
  localparam int MASK_MSB      = 24;
  localparam int MASK_LSB      = 13;
  localparam int INDEX_MSB     = LOG2_TLB_LINE_NUM - 1;
  localparam int INDEX_P_BIT   = 31;
  localparam int BADVPN2_SHIFT = VPN2_LSB - 4;  // bad_vaddr[31:13] -> Context[22:4]

  // Writable / loadable bit masks per register
  localparam logic [31:0] INDEX_WMASK     = 32'(TLB_LINE_NUM - 1);
  localparam logic [31:0] INDEX_LMASK     = 32'h8000_0000 | INDEX_WMASK;
  localparam logic [31:0] ENTRYLO_WMASK   = 32'h03FF_FFFF;
  localparam logic [31:0] CONTEXT_WMASK   = 32'hFF80_0000;
  localparam logic [31:0] BADVPN2_MASK    = 32'h007F_FFF0;
  localparam logic [31:0] PAGEMASK_WMASK  = 32'h01FF_E000;
  localparam logic [31:0] ENTRYHI_WMASK   = 32'hFFFF_E0FF;
  localparam logic [31:0] VPN2_MASK       = 32'hFFFF_E000;

  // Zero-extend a TLB index-sized value to a 32-bit register image
  function automatic logic [31:0] zext_idx(input logic [LOG2_TLB_LINE_NUM-1:0] v);
    return {{(32 - LOG2_TLB_LINE_NUM){1'b0}}, v};
  endfunction

endpackage

// File: rtl/cp0_tlb_regs_random_ctr.sv
// Random/Wired pair: Random counts down each enabled cycle, wrapping to the
// reset value when it reaches Wired; a Wired write reloads Random.
module cp0_random_ctr #(
  parameter int W            = 5,
  parameter int RESET_RANDOM = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         wired_we_i,
  input  logic [W-1:0] wired_wdata_i,
  output logic [W-1:0] random_o,
  output logic [W-1:0] wired_o
);

  localparam logic [W-1:0] RESET_VAL = W'(RESET_RANDOM);

  logic [W-1:0] random_q, random_d;
  logic [W-1:0] wired_q,  wired_d;

  // Next-state: Wired write reloads, saturated Wired pins, otherwise count down/wrap
  always_comb begin
    wired_d  = wired_q;
    random_d = random_q;
    if (wired_we_i) begin
      wired_d  = wired_wdata_i;
      random_d = RESET_VAL;
    end else if (wired_q >= RESET_VAL) begin
      random_d = RESET_VAL;
    end else if (random_q == wired_q) begin
      random_d = RESET_VAL;
    end else begin
      random_d = random_q - 1'b1;
    end
  end

  // State registers, frozen while the pipeline stage is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      random_q <= RESET_VAL;
      wired_q  <= '0;
    end else if (en_i) begin
      random_q <= random_d;
      wired_q  <= wired_d;
    end
  end

  assign random_o = random_q;
  assign wired_o  = wired_q;

endmodule

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB-management registers (Index, Random, EntryLo0/1, Context,
// PageMask, Wired, EntryHi) feeding the TLB; updated from MTC0, TLBP/TLBR
// results and TLB-exception address capture in M stage.
module cp0_tlb_regs
  import cp0_tlb_regs_pkg::*;
#(
  parameter int RESET_RANDOM = TLB_LINE_NUM - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM,
  input  logic        mtc0_en,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic        TLBP,
  input  logic        TLBR,
  input  logic [31:0] tlbp_index_in,
  input  logic [31:0] tlbr_entryhi_in,
  input  logic [31:0] tlbr_pagemask_in,
  input  logic [31:0] tlbr_entrylo0_in,
  input  logic [31:0] tlbr_entrylo1_in,
  input  logic        tlb_exc,
  input  logic [31:0] bad_vaddr,
  output logic [31:0] EntryHi_out,
  output logic [31:0] PageMask_out,
  output logic [31:0] EntryLo0_out,
  output logic [31:0] EntryLo1_out,
  output logic [31:0] Index_out,
  output logic [31:0] Random_out
);

  logic [31:0] index_q,    index_d;
  logic [31:0] entrylo0_q, entrylo0_d;
  logic [31:0] entrylo1_q, entrylo1_d;
  logic [31:0] context_q,  context_d;
  logic [31:0] pagemask_q, pagemask_d;
  logic [31:0] entryhi_q,  entryhi_d;
  logic [LOG2_TLB_LINE_NUM-1:0] random_w, wired_w;

  // TLBR wins over TLBP if decode ever lets both through
  logic tlbp_eff;
  assign tlbp_eff = TLBP & ~TLBR;

  cp0_random_ctr #(
    .W            (LOG2_TLB_LINE_NUM),
    .RESET_RANDOM (RESET_RANDOM)
  ) u_random_ctr (
    .clk           (clk),
    .rst           (rst),
    .en_i          (~stallM),
    .wired_we_i    (mtc0_en && (cp0_waddr == CP0_WIRED)),
    .wired_wdata_i (cp0_wdata[LOG2_TLB_LINE_NUM-1:0]),
    .random_o      (random_w),
    .wired_o       (wired_w)
  );

  // Next-state per register; priority tlb_exc > TLBR/TLBP > MTC0
  always_comb begin
    index_d    = index_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    context_d  = context_q;
    pagemask_d = pagemask_q;
    entryhi_d  = entryhi_q;

    if (tlbp_eff)
      index_d = tlbp_index_in & INDEX_LMASK;
    else if (mtc0_en && cp0_waddr == CP0_INDEX)
      index_d = (index_q & ~INDEX_WMASK) | (cp0_wdata & INDEX_WMASK);

    if (TLBR)
      entrylo0_d = tlbr_entrylo0_in & ENTRYLO_WMASK;
    else if (mtc0_en && cp0_waddr == CP0_ENTRYLO0)
      entrylo0_d = cp0_wdata & ENTRYLO_WMASK;

    if (TLBR)
      entrylo1_d = tlbr_entrylo1_in & ENTRYLO_WMASK;
    else if (mtc0_en && cp0_waddr == CP0_ENTRYLO1)
      entrylo1_d = cp0_wdata & ENTRYLO_WMASK;

    if (TLBR)
      pagemask_d = tlbr_pagemask_in & PAGEMASK_WMASK;
    else if (mtc0_en && cp0_waddr == CP0_PAGEMASK)
      pagemask_d = cp0_wdata & PAGEMASK_WMASK;

    if (tlb_exc)
      context_d = (context_q & ~BADVPN2_MASK) | ((bad_vaddr & VPN2_MASK) >> BADVPN2_SHIFT);
    else if (mtc0_en && cp0_waddr == CP0_CONTEXT)
      context_d = (context_q & ~CONTEXT_WMASK) | (cp0_wdata & CONTEXT_WMASK);

    // TLB stores G at bit 12; the mask keeps it out of EntryHi
    if (tlb_exc)
      entryhi_d = (entryhi_q & ~VPN2_MASK) | (bad_vaddr & VPN2_MASK);
    else if (TLBR)
      entryhi_d = tlbr_entryhi_in & ENTRYHI_WMASK;
    else if (mtc0_en && cp0_waddr == CP0_ENTRYHI)
      entryhi_d = cp0_wdata & ENTRYHI_WMASK;
  end

  // Register bank, frozen while M is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      context_q  <= '0;
      pagemask_q <= '0;
      entryhi_q  <= '0;
    end else if (!stallM) begin
      index_q    <= index_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      context_q  <= context_d;
      pagemask_q <= pagemask_d;
      entryhi_q  <= entryhi_d;
    end
  end

  // MFC0 read mux; unimplemented numbers read zero
  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      CP0_INDEX:    cp0_rdata = index_q;
      CP0_RANDOM:   cp0_rdata = zext_idx(random_w);
      CP0_ENTRYLO0: cp0_rdata = entrylo0_q;
      CP0_ENTRYLO1: cp0_rdata = entrylo1_q;
      CP0_CONTEXT:  cp0_rdata = context_q;
      CP0_PAGEMASK: cp0_rdata = pagemask_q;
      CP0_WIRED:    cp0_rdata = zext_idx(wired_w);
      CP0_ENTRYHI:  cp0_rdata = entryhi_q;
      default:      cp0_rdata = '0;
    endcase
  end

  assign EntryHi_out  = entryhi_q;
  assign PageMask_out = pagemask_q;
  assign EntryLo0_out = entrylo0_q;
  assign EntryLo1_out = entrylo1_q;
  assign Index_out    = index_q;
  assign Random_out   = zext_idx(random_w);

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Randomized bench for cp0_tlb_regs against a field-level reference model,
// preceded by directed sequences for the documented corner cases.
module tb_cp0_tlb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallM, mtc0_en, TLBP, TLBR, tlb_exc;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic [31:0] tlbp_index_in, tlbr_entryhi_in, tlbr_pagemask_in;
  logic [31:0] tlbr_entrylo0_in, tlbr_entrylo1_in, bad_vaddr;
  logic [31:0] EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out, Random_out;

  always #20 clk = ~clk;

  cp0_tlb_regs dut (
    .clk              (clk),
    .rst              (rst),
    .stallM           (stallM),
    .mtc0_en          (mtc0_en),
    .cp0_waddr        (cp0_waddr),
    .cp0_wdata        (cp0_wdata),
    .cp0_raddr        (cp0_raddr),
    .cp0_rdata        (cp0_rdata),
    .TLBP             (TLBP),
    .TLBR             (TLBR),
    .tlbp_index_in    (tlbp_index_in),
    .tlbr_entryhi_in  (tlbr_entryhi_in),
    .tlbr_pagemask_in (tlbr_pagemask_in),
    .tlbr_entrylo0_in (tlbr_entrylo0_in),
    .tlbr_entrylo1_in (tlbr_entrylo1_in),
    .tlb_exc          (tlb_exc),
    .bad_vaddr        (bad_vaddr),
    .EntryHi_out      (EntryHi_out),
    .PageMask_out     (PageMask_out),
    .EntryLo0_out     (EntryLo0_out),
    .EntryLo1_out     (EntryLo1_out),
    .Index_out        (Index_out),
    .Random_out       (Random_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural fields held as plain integers
  bit          m_p;
  int unsigned m_idx, m_rand, m_wired, m_el0, m_el1, m_pte, m_bad, m_pm, m_vpn2, m_asid;

  task automatic model_reset();
    m_p = 0; m_idx = 0; m_rand = 31; m_wired = 0; m_el0 = 0; m_el1 = 0;
    m_pte = 0; m_bad = 0; m_pm = 0; m_vpn2 = 0; m_asid = 0;
  endtask

  function automatic logic [31:0] exp_reg(input int a);
    logic [31:0] r;
    case (a)
      0:  r = (m_p ? 32'h8000_0000 : 32'h0) | 32'(m_idx);
      1:  r = 32'(m_rand);
      2:  r = 32'(m_el0);
      3:  r = 32'(m_el1);
      4:  r = (32'(m_pte) << 23) | (32'(m_bad) << 4);
      5:  r = 32'(m_pm) << 13;
      6:  r = 32'(m_wired);
      10: r = (32'(m_vpn2) << 13) | 32'(m_asid);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // One unstalled clock edge applied to the model from the driven inputs
  task automatic model_update();
    if (mtc0_en && cp0_waddr == 5'd6) begin
      m_wired = cp0_wdata % 32;
      m_rand  = 31;
    end else if (m_wired >= 31 || m_rand == m_wired) begin
      m_rand = 31;
    end else begin
      m_rand = m_rand - 1;
    end

    if (TLBP && !TLBR) begin
      m_p   = tlbp_index_in[31];
      m_idx = tlbp_index_in % 32;
    end else if (mtc0_en && cp0_waddr == 5'd0) begin
      m_idx = cp0_wdata % 32;
    end

    if (TLBR) begin
      m_el0 = tlbr_entrylo0_in % (1 << 26);
      m_el1 = tlbr_entrylo1_in % (1 << 26);
      m_pm  = (tlbr_pagemask_in >> 13) % 4096;
    end else if (mtc0_en) begin
      if (cp0_waddr == 5'd2) m_el0 = cp0_wdata % (1 << 26);
      if (cp0_waddr == 5'd3) m_el1 = cp0_wdata % (1 << 26);
      if (cp0_waddr == 5'd5) m_pm  = (cp0_wdata >> 13) % 4096;
    end

    if (tlb_exc)                                m_bad = bad_vaddr >> 13;
    else if (mtc0_en && cp0_waddr == 5'd4)      m_pte = cp0_wdata >> 23;

    if (tlb_exc) begin
      m_vpn2 = bad_vaddr >> 13;
    end else if (TLBR) begin
      m_vpn2 = tlbr_entryhi_in >> 13;
      m_asid = tlbr_entryhi_in % 256;
    end else if (mtc0_en && cp0_waddr == 5'd10) begin
      m_vpn2 = cp0_wdata >> 13;
      m_asid = cp0_wdata % 256;
    end
  endtask

  int rd_addrs[11] = '{0, 1, 2, 3, 4, 5, 6, 10, 7, 15, 31};

  task automatic check_all();
    chk("Index_out",    Index_out,    exp_reg(0));
    chk("Random_out",   Random_out,   exp_reg(1));
    chk("EntryLo0_out", EntryLo0_out, exp_reg(2));
    chk("EntryLo1_out", EntryLo1_out, exp_reg(3));
    chk("PageMask_out", PageMask_out, exp_reg(5));
    chk("EntryHi_out",  EntryHi_out,  exp_reg(10));
    foreach (rd_addrs[k]) begin
      cp0_raddr = 5'(rd_addrs[k]);
      #1;
      chk($sformatf("rdata_r%0d", rd_addrs[k]), cp0_rdata, exp_reg(rd_addrs[k]));
    end
  endtask

  task automatic idle();
    stallM = 0; mtc0_en = 0; TLBP = 0; TLBR = 0; tlb_exc = 0;
  endtask

  // Apply the currently driven inputs across one edge, then check everything
  task automatic tick();
    @(posedge clk);
    if (rst && !stallM) model_update();
    #1;
    check_all();
    $display("txn t=%0t rst=%b stall=%b mtc0=%b waddr=%0d wdata=%08h TLBP=%b TLBR=%b exc=%b Random=%0d EntryHi=%08h Index=%08h",
             $time, rst, stallM, mtc0_en, cp0_waddr, cp0_wdata, TLBP, TLBR, tlb_exc,
             Random_out, EntryHi_out, Index_out);
    @(negedge clk);
    idle();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1; cp0_waddr = a; cp0_wdata = d;
  endtask

  initial begin
    rst = 0;
    idle();
    cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 0;
    tlbp_index_in = 0; tlbr_entryhi_in = 0; tlbr_pagemask_in = 0;
    tlbr_entrylo0_in = 0; tlbr_entrylo1_in = 0; bad_vaddr = 0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1;

    // Random counts down from 31 with Wired=0, holds while stalled
    chk("t1_rand_start", Random_out, 32'd31);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_rand_dec", Random_out, 32'(31 - i));
    end
    for (int i = 0; i < 3; i++) begin
      stallM = 1;
      tick();
      chk("t1_rand_stall", Random_out, 32'd27);
    end

    // Wired=30: reload, then wrap between 31 and 30; Wired=31 pins Random
    mtc0(5'd6, 32'd30); tick(); chk("t2_reload", Random_out, 32'd31);
    tick(); chk("t2_dec", Random_out, 32'd30);
    tick(); chk("t2_wrap", Random_out, 32'd31);
    tick(); chk("t2_dec2", Random_out, 32'd30);
    mtc0(5'd6, 32'd31); tick(); chk("t2_w31", Random_out, 32'd31);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t2_w31_hold", Random_out, 32'd31);
    end
    mtc0(5'd6, 32'd0); tick();

    // Writable-bit masking
    mtc0(5'd10, 32'hFFFF_FFFF); tick(); chk("t3_entryhi", EntryHi_out, 32'hFFFF_E0FF);
    mtc0(5'd5,  32'hFFFF_FFFF); tick(); chk("t3_pagemask", PageMask_out, 32'h01FF_E000);
    mtc0(5'd2,  32'hFFFF_FFFF); tick(); chk("t3_entrylo0", EntryLo0_out, 32'h03FF_FFFF);

    // TLBP results
    TLBP = 1; tlbp_index_in = 32'h8000_0000; tick(); chk("t4_probe_miss", Index_out, 32'h8000_0000);
    TLBP = 1; tlbp_index_in = 32'h0000_0007; tick(); chk("t4_probe_hit", Index_out, 32'h0000_0007);

    // TLBR load with G bit at 12 stripped
    TLBR = 1;
    tlbr_entryhi_in  = 32'h1234_5F0A;
    tlbr_pagemask_in = $urandom;
    tlbr_entrylo0_in = $urandom;
    tlbr_entrylo1_in = $urandom;
    tick(); chk("t5_entryhi", EntryHi_out, 32'h1234_400A);

    // tlb_exc beats a same-cycle MTC0 to EntryHi
    mtc0(5'd10, 32'h0); tick();
    mtc0(5'd10, 32'h0000_00AB); tlb_exc = 1; bad_vaddr = 32'h8765_4321;
    tick(); chk("t6_entryhi", EntryHi_out, 32'h8765_4000);
    cp0_raddr = 5'd4;
    #1;
    chk("t6_badvpn2", (cp0_rdata >> 4) & 32'h0007_FFFF, 32'h0004_3B2A);

    // Randomized traffic, with one asynchronous reset in the middle
    for (int n = 0; n < 500; n++) begin
      stallM  = ($urandom % 8) == 0;
      mtc0_en = $urandom % 2;
      cp0_waddr = 5'(rd_addrs[$urandom % 11]);
      cp0_wdata = $urandom;
      begin
        int r;
        r = $urandom % 8;
        TLBP = (r == 1) || (r == 3);
        TLBR = (r == 2) || (r == 3);
      end
      tlb_exc          = ($urandom % 6) == 0;
      tlbp_index_in    = $urandom;
      tlbr_entryhi_in  = $urandom;
      tlbr_pagemask_in = $urandom;
      tlbr_entrylo0_in = $urandom;
      tlbr_entrylo1_in = $urandom;
      bad_vaddr        = $urandom;
      if (n == 250) begin
        #2;
        rst = 0;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_tlb_regs.md
Name: cp0_tlb_regs

Overview:
CP0 TLB-management register file that sits directly upstream of the TLB lookup/translation unit. It supplies EntryHi, PageMask, EntryLo0/1, Index and Random to the TLB. It absorbs TLBP/TLBR results and TLB-exception address capture. It serves MTC0/MFC0 for registers 0–6 and 10, all in M stage.

Parameters:
TLB_LINE_NUM, 32, TLB entries; Index, Random and Wired are log2(TLB_LINE_NUM) bits wide.
RESET_RANDOM, TLB_LINE_NUM-1, Random reset and wrap value.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (rst=0 resets all state)
stallM  in  1  M stage stalled; blocks every state update
mtc0_en  in  1  MTC0 in M
cp0_waddr  in  5  MTC0 register number (sel fixed 0)
cp0_wdata  in  32  MTC0 data
cp0_raddr  in  5  MFC0 register number
cp0_rdata  out  32  MFC0 data, combinational
TLBP, TLBR  in  1 each  TLB instruction in M
tlbp_index_in  in  32  TLB Index_out (P bit31 | index)
tlbr_entryhi_in, tlbr_pagemask_in, tlbr_entrylo0_in, tlbr_entrylo1_in  in  32 each  TLB read data
tlb_exc  in  1  TLB refill/invalid/modify taken in M
bad_vaddr  in  32  faulting virtual address
EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out, Random_out  out  32 each  registered values to TLB

Behaviour:
- All updates occur on posedge clk only when stallM=0. Reset is asynchronous on rst falling.
- Reset values: all registers 0 except Random=RESET_RANDOM. cp0_rdata follows cp0_raddr combinationally after reset.
- Index (0): bit31 P, [4:0] index, other bits read 0.
  - MTC0 writes [4:0] only; P unchanged.
  - TLBP loads {tlbp_index_in[31], 26'b0, tlbp_index_in[4:0]}.
- Random (1): read-only to MTC0; decrements by 1 every unstalled cycle.
  - If Random==Wired, next value is RESET_RANDOM.
  - If Wired>=RESET_RANDOM, Random holds at RESET_RANDOM.
  - MTC0 to Wired forces Random=RESET_RANDOM in the same edge.
  - TLBWR uses the pre-edge value; the TLB sees Random_out.
- EntryLo0/1 (2/3): [25:0] writable (PFN[25:6], C[5:3], D2, V1, G0); [31:26] read 0. TLBR loads masked tlbr_entrylo*_in.
- Context (4): PTEBase [31:23] MTC0-writable; BadVPN2 [22:4] ← bad_vaddr[31:13] on tlb_exc; [3:0]=0.
- PageMask (5): only [24:13] writable/loadable; rest 0.
- Wired (6): [4:0] writable, rest 0.
- EntryHi (10): VPN2 [31:13], ASID [7:0]; [12:8] always 0.
  - TLBR loads with [12:8] cleared; the TLB stores G at bit12, and it must not leak.
  - tlb_exc writes VPN2 ← bad_vaddr[31:13]; ASID unchanged.
- Unimplemented register numbers read 0; MTC0 to them is ignored.
- Same-register, same-cycle priority: tlb_exc > TLBR/TLBP > MTC0.
- TLBP and TLBR are mutually exclusive by decode; if both arrive, TLBR wins and TLBP is ignored.
- Latency: writes are visible on outputs and cp0_rdata the cycle after the edge. No bypass: back-to-back MTC0→TLBWI is correct because both execute in M in successive cycles.
- Reset mid-operation discards pending updates; Random returns to RESET_RANDOM.

Decomposition:
- Shared defines: CP0 register numbers, TLB_LINE_NUM/LOG2_TLB_LINE_NUM, and field ranges (VPN2_BITS, ASID_BITS, PFN_BITS, C_BITS, D_BIT, V_BIT, MASK_BITS, INDEX_BITS), plus writable-bit masks per register.
- One sub-module, cp0_random_ctr: Random/Wired counter with wrap and force-reload.

Test Plan:
1. Reset, then hold 5 unstalled cycles with Wired=0 → Random 31,30,29,28,27; stallM=1 for 3 cycles → Random holds at 27.
2. MTC0 Wired=30 → Random=31 next cycle, then 30, then 31 (wrap at Wired), repeating; Wired=31 → Random stuck at 31.
3. MTC0 EntryHi=0xFFFF_FFFF → reads 0xFFFF_E0FF; MTC0 PageMask=0xFFFF_FFFF → reads 0x01FF_E000; MTC0 EntryLo0=0xFFFF_FFFF → 0x03FF_FFFF.
4. TLBP with tlbp_index_in=0x8000_0000 → Index=0x8000_0000; then 0x0000_0007 → Index=0x0000_0007.
5. TLBR with tlbr_entryhi_in=0x1234_5F0A → EntryHi=0x1234_400A; the other three registers load their masked inputs.
6. MTC0 EntryHi=0x0000_00AB together with tlb_exc, bad_vaddr=0x8765_4321 → EntryHi=0x8765_4000 (ASID keeps its old value, exc wins); Context[22:4]=0x43B2A.
